// File: rtl/wb_arbiter_2_if.sv
// Wishbone bus bundle shared by the arbiter's master-side and slave-side ports.
// The master modport drives the request; the slave modport drives the response.
interface wb_arbiter_2_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    we;
  logic [SELECT_WIDTH-1:0] sel;
  logic                    stb;
  logic                    cyc;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/wb_arbiter_2.sv
// Two-master to one-slave Wishbone arbiter: m0 = data port, m1 = instruction fetch.
// Grant is held for a master's whole cyc; hung transfers are ended with a timeout err.
module wb_arbiter_2 #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ROUND_ROBIN  = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic           clk,
  input  logic           rst,
  wb_arbiter_2_if.slave  m0,
  wb_arbiter_2_if.slave  m1,
  wb_arbiter_2_if.master s,
  output logic [1:0]     grant_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StG0   = 2'd1;
  localparam logic [1:0] StG1   = 2'd2;

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

  logic [1:0]      state_q, state_d;
  logic            last_q, last_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            to_err_q, to_err_d;

  logic req0, req1, g0, g1, resp;
  logic [ADDR_WIDTH-1:0]   adr_mux;
  logic [DATA_WIDTH-1:0]   dat_mux;
  logic [SELECT_WIDTH-1:0] sel_mux;
  logic we_mux, cyc_mux, stb_mux, s_stb_int;

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;
  assign g0   = (state_q == StG0);
  assign g1   = (state_q == StG1);
  assign resp = s.ack | s.err | s.rty;

  // last_q records the most recently granted master (0 = m0, 1 = m1).
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          if ((ROUND_ROBIN != 0) && !last_q) begin
            state_d = StG1;
            last_d  = 1'b1;
          end else begin
            state_d = StG0;
            last_d  = 1'b0;
          end
        end else if (req0) begin
          state_d = StG0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = StG1;
          last_d  = 1'b1;
        end
      end
      StG0:    if (!m0.cyc) state_d = StIdle;
      StG1:    if (!m1.cyc) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    adr_mux = '0;
    dat_mux = '0;
    sel_mux = '0;
    we_mux  = 1'b0;
    cyc_mux = 1'b0;
    stb_mux = 1'b0;
    if (g0) begin
      adr_mux = m0.adr;
      dat_mux = m0.dat_w;
      sel_mux = m0.sel;
      we_mux  = m0.we;
      cyc_mux = m0.cyc;
      stb_mux = m0.stb;
    end else if (g1) begin
      adr_mux = m1.adr;
      dat_mux = m1.dat_w;
      sel_mux = m1.sel;
      we_mux  = m1.we;
      cyc_mux = m1.cyc;
      stb_mux = m1.stb;
    end
  end

  assign s_stb_int = stb_mux & ~to_err_q;

  // The timeout cycle itself drops stb, so the count naturally restarts on the next beat.
  always_comb begin
    wait_cnt_d = '0;
    to_err_d   = 1'b0;
    if ((TIMEOUT != 0) && (state_q != StIdle) && s_stb_int && !resp) begin
      if (wait_cnt_q == CntLast) begin
        to_err_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      wait_cnt_q <= '0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
      to_err_q   <= to_err_d;
    end
  end

  assign s.adr   = adr_mux;
  assign s.dat_w = dat_mux;
  assign s.sel   = sel_mux;
  assign s.we    = we_mux;
  assign s.cyc   = cyc_mux & ~to_err_q;
  assign s.stb   = s_stb_int;

  // Responses depend only on slave inputs and local state, never on the other master.
  assign m0.ack   = s.ack & g0;
  assign m0.rty   = s.rty & g0;
  assign m0.err   = (s.err | to_err_q) & g0;
  assign m0.dat_r = g0 ? s.dat_r : '0;

  assign m1.ack   = s.ack & g1;
  assign m1.rty   = s.rty & g1;
  assign m1.err   = (s.err | to_err_q) & g1;
  assign m1.dat_r = g1 ? s.dat_r : '0;

  assign grant_o = {g1, g0};

endmodule

// File: tb/tb_wb_arbiter_2.sv
// Bench for wb_arbiter_2: dut0 is round-robin with TIMEOUT=4, dut1 fixed-priority with no
// timeout; both see identical stimulus and are compared to a pending-cycle reference model.
module tb_wb_arbiter_2;
  localparam int unsigned Dw = 32;
  localparam int unsigned Aw = 32;
  localparam int unsigned Sw = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [Aw-1:0] m_adr [2];
  logic [Dw-1:0] m_dw  [2];
  logic [Sw-1:0] m_sel [2];
  logic          s_ack, s_err, s_rty;
  logic [Dw-1:0] s_dr;

  logic [1:0]    grant  [2];
  logic          s_cyc  [2];
  logic          s_stb  [2];
  logic          s_we   [2];
  logic [Sw-1:0] s_sel  [2];
  logic [Aw-1:0] s_adr  [2];
  logic [Dw-1:0] s_dw   [2];
  logic [1:0]    m_ack  [2];
  logic [1:0]    m_err  [2];
  logic [1:0]    m_rty  [2];
  logic [Dw-1:0] m0_dr  [2];
  logic [Dw-1:0] m1_dr  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arbiter_2_if #(.DATA_WIDTH(Dw), .ADDR_WIDTH(Aw), .SELECT_WIDTH(Sw)) m0_if ();
    wb_arbiter_2_if #(.DATA_WIDTH(Dw), .ADDR_WIDTH(Aw), .SELECT_WIDTH(Sw)) m1_if ();
    wb_arbiter_2_if #(.DATA_WIDTH(Dw), .ADDR_WIDTH(Aw), .SELECT_WIDTH(Sw)) s_if ();
    logic [1:0] grant_w;

    assign m0_if.adr   = m_adr[0];
    assign m0_if.dat_w = m_dw[0];
    assign m0_if.we    = m_we[0];
    assign m0_if.sel   = m_sel[0];
    assign m0_if.stb   = m_stb[0];
    assign m0_if.cyc   = m_cyc[0];
    assign m1_if.adr   = m_adr[1];
    assign m1_if.dat_w = m_dw[1];
    assign m1_if.we    = m_we[1];
    assign m1_if.sel   = m_sel[1];
    assign m1_if.stb   = m_stb[1];
    assign m1_if.cyc   = m_cyc[1];
    assign s_if.ack    = s_ack;
    assign s_if.err    = s_err;
    assign s_if.rty    = s_rty;
    assign s_if.dat_r  = s_dr;

    wb_arbiter_2 #(
      .DATA_WIDTH  (Dw),
      .ADDR_WIDTH  (Aw),
      .SELECT_WIDTH(Sw),
      .ROUND_ROBIN ((g == 0) ? 1 : 0),
      .TIMEOUT     ((g == 0) ? 4 : 0)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .m0     (m0_if),
      .m1     (m1_if),
      .s      (s_if),
      .grant_o(grant_w)
    );

    assign grant[g] = grant_w;
    assign s_cyc[g] = s_if.cyc;
    assign s_stb[g] = s_if.stb;
    assign s_we[g]  = s_if.we;
    assign s_sel[g] = s_if.sel;
    assign s_adr[g] = s_if.adr;
    assign s_dw[g]  = s_if.dat_w;
    assign m_ack[g] = {m1_if.ack, m0_if.ack};
    assign m_err[g] = {m1_if.err, m0_if.err};
    assign m_rty[g] = {m1_if.rty, m0_if.rty};
    assign m0_dr[g] = m0_if.dat_r;
    assign m1_dr[g] = m1_if.dat_r;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: owner (-1 idle), last winner, and the number of consecutive cycles the
  // current owner's strobe has been on the slave without any response.
  int owner  [2];
  int last   [2];
  int streak [2];

  function automatic int rr_of(int g);
    return (g == 0) ? 1 : 0;
  endfunction

  function automatic int to_of(int g);
    return (g == 0) ? 4 : 0;
  endfunction

  function automatic bit err_now(int g);
    return (to_of(g) > 0) && (streak[g] == to_of(g));
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      owner[g]  = -1;
      last[g]   = 1;
      streak[g] = 0;
    end
  endtask

  task automatic model_check();
    for (int g = 0; g < 2; g++) begin
      logic [14:0]   ctl_e, ctl_a;
      logic [Aw-1:0] adr_e;
      logic [Dw-1:0] dw_e, dr0_e, dr1_e;
      logic [1:0]    gr, ack, err, rty;
      int o;
      bit e;
      o = owner[g];
      e = err_now(g);
      ctl_e = '0;
      adr_e = '0;
      dw_e  = '0;
      dr0_e = '0;
      dr1_e = '0;
      if (o >= 0) begin
        gr = '0;  gr[o] = 1'b1;
        ack = '0; ack[o] = s_ack;
        err = '0; err[o] = s_err | e;
        rty = '0; rty[o] = s_rty;
        ctl_e = {gr, m_cyc[o] & ~e, m_stb[o] & ~e, m_we[o], m_sel[o], ack, err, rty};
        adr_e = m_adr[o];
        dw_e  = m_dw[o];
        if (o == 0) dr0_e = s_dr;
        else        dr1_e = s_dr;
      end
      ctl_a = {grant[g], s_cyc[g], s_stb[g], s_we[g], s_sel[g], m_ack[g], m_err[g], m_rty[g]};
      check($sformatf("dut%0d ctl", g), ctl_a, ctl_e);
      check($sformatf("dut%0d s_adr", g), s_adr[g], adr_e);
      check($sformatf("dut%0d s_dat", g), s_dw[g], dw_e);
      check($sformatf("dut%0d m0_dat", g), m0_dr[g], dr0_e);
      check($sformatf("dut%0d m1_dat", g), m1_dr[g], dr1_e);
    end
  endtask

  task automatic model_advance();
    for (int g = 0; g < 2; g++) begin
      bit req0, req1, e, stb, resp;
      int o;
      req0 = m_cyc[0] & m_stb[0];
      req1 = m_cyc[1] & m_stb[1];
      if (owner[g] < 0) begin
        streak[g] = 0;
        if (req0 && req1) owner[g] = (rr_of(g) != 0) ? 1 - last[g] : 0;
        else if (req0)    owner[g] = 0;
        else if (req1)    owner[g] = 1;
        if (owner[g] >= 0) last[g] = owner[g];
      end else begin
        o    = owner[g];
        e    = err_now(g);
        stb  = m_stb[o] & ~e;
        resp = s_ack | s_err | s_rty;
        streak[g] = (stb && !resp) ? streak[g] + 1 : 0;
        if (!m_cyc[o]) begin
          owner[g]  = -1;
          streak[g] = 0;
        end
      end
    end
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      m_we[m]  = 1'b0;
      m_adr[m] = '0;
      m_dw[m]  = '0;
      m_sel[m] = '0;
    end
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    s_dr  = '0;
  endtask

  // Sample in the low phase, then advance the model and cross the rising edge.
  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("dut%0d reset grant", g), grant[g], 2'b00);
      check($sformatf("dut%0d reset s_cyc", g), s_cyc[g], 1'b0);
    end
    model_check();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic          c0, s0, c1, s1, ack;
    logic [Dw-1:0] dat;
    logic [1:0]    ga, gb;
    logic          sstb, m0ack, m1ack;
    logic [Dw-1:0] m1dat;
  } vec_t;

  vec_t vecs [18];

  initial begin
    vecs[0]  = '{0, 0, 1, 1, 0, 32'h0,        2'b00, 2'b00, 0, 0, 0, 32'h0};
    vecs[1]  = '{0, 0, 1, 1, 0, 32'h0,        2'b10, 2'b10, 1, 0, 0, 32'h0};
    vecs[2]  = '{0, 0, 1, 1, 1, 32'hDEADBEEF, 2'b10, 2'b10, 1, 0, 1, 32'hDEADBEEF};
    vecs[3]  = '{0, 0, 0, 0, 0, 32'h0,        2'b10, 2'b10, 0, 0, 0, 32'h0};
    vecs[4]  = '{1, 1, 1, 1, 0, 32'h0,        2'b00, 2'b00, 0, 0, 0, 32'h0};
    vecs[5]  = '{1, 1, 1, 1, 0, 32'h0,        2'b01, 2'b01, 1, 0, 0, 32'h0};
    vecs[6]  = '{0, 0, 1, 1, 0, 32'h0,        2'b01, 2'b01, 0, 0, 0, 32'h0};
    vecs[7]  = '{1, 1, 1, 1, 0, 32'h0,        2'b00, 2'b00, 0, 0, 0, 32'h0};
    vecs[8]  = '{1, 1, 1, 1, 0, 32'h0,        2'b10, 2'b01, 1, 0, 0, 32'h0};
    vecs[9]  = '{0, 0, 0, 0, 0, 32'h0,        2'b10, 2'b01, 0, 0, 0, 32'h0};
    vecs[10] = '{1, 1, 1, 1, 0, 32'h0,        2'b00, 2'b00, 0, 0, 0, 32'h0};
    vecs[11] = '{1, 1, 1, 1, 1, 32'h0,        2'b01, 2'b01, 1, 1, 0, 32'h0};
    vecs[12] = '{1, 0, 1, 1, 0, 32'h0,        2'b01, 2'b01, 0, 0, 0, 32'h0};
    vecs[13] = '{1, 1, 1, 1, 1, 32'h0,        2'b01, 2'b01, 1, 1, 0, 32'h0};
    vecs[14] = '{1, 0, 1, 1, 0, 32'h0,        2'b01, 2'b01, 0, 0, 0, 32'h0};
    vecs[15] = '{1, 1, 1, 1, 1, 32'h0,        2'b01, 2'b01, 1, 1, 0, 32'h0};
    vecs[16] = '{0, 0, 1, 1, 1, 32'h0,        2'b01, 2'b01, 0, 1, 0, 32'h0};
    vecs[17] = '{0, 0, 0, 0, 0, 32'h0,        2'b00, 2'b00, 0, 0, 0, 32'h0};

    // Directed table: single m1 read, round-robin vs fixed contention, held grant.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      m_cyc[0] = vecs[i].c0;
      m_stb[0] = vecs[i].s0;
      m_cyc[1] = vecs[i].c1;
      m_stb[1] = vecs[i].s1;
      s_ack    = vecs[i].ack;
      s_dr     = vecs[i].dat;
      sample();
      check($sformatf("row%0d dut0 grant", i), grant[0], vecs[i].ga);
      check($sformatf("row%0d dut1 grant", i), grant[1], vecs[i].gb);
      check($sformatf("row%0d s_stb", i), s_stb[0], vecs[i].sstb);
      check($sformatf("row%0d m0_ack", i), m_ack[0][0], vecs[i].m0ack);
      check($sformatf("row%0d m1_ack", i), m_ack[0][1], vecs[i].m1ack);
      check($sformatf("row%0d m1_dat", i), m1_dr[0], vecs[i].m1dat);
      tick();
    end

    // Timeout: err 4 cycles after stb first rose, ack on the deciding cycle wins.
    do_reset();
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_adr[0] = 32'h0000_0100;
    for (int c = 0; c < 15; c++) begin
      bit to_cyc;
      to_cyc = (c == 5) || (c == 14);
      s_ack = (c == 9);
      sample();
      check($sformatf("to c%0d m0_err", c), m_err[0][0], to_cyc);
      check($sformatf("to c%0d s_stb", c), s_stb[0], (c >= 1) && !to_cyc);
      check($sformatf("to c%0d s_cyc", c), s_cyc[0], (c >= 1) && !to_cyc);
      check($sformatf("to c%0d m0_ack", c), m_ack[0][0], c == 9);
      check($sformatf("to c%0d grant", c), grant[0], (c >= 1) ? 2'b01 : 2'b00);
      check($sformatf("to c%0d nto err", c), m_err[1][0], 1'b0);
      tick();
    end
    clear_inputs();
    repeat (2) begin
      sample();
      tick();
    end

    // Async reset mid-transfer on m1, then m0 wins the first contention.
    do_reset();
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    sample();
    tick();
    sample();
    check("pre-reset grant", grant[0], 2'b10);
    check("pre-reset s_stb", s_stb[0], 1'b1);
    rst = 1'b0;
    #1;
    model_reset();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("dut%0d async s_cyc", g), s_cyc[g], 1'b0);
      check($sformatf("dut%0d async grant", g), grant[g], 2'b00);
      check($sformatf("dut%0d async m1_ack", g), m_ack[g], 2'b00);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    sample();
    check("post-reset idle", grant[0], 2'b00);
    tick();
    sample();
    check("post-reset dut0 grant", grant[0], 2'b01);
    check("post-reset dut1 grant", grant[1], 2'b01);
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(7) == 0) m_cyc[m] = ~m_cyc[m];
        m_stb[m] = m_cyc[m] ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
        m_adr[m] = $urandom;
        m_dw[m]  = $urandom;
        m_we[m]  = 1'($urandom_range(1));
        m_sel[m] = 4'($urandom_range(15));
      end
      s_ack = ($urandom_range(5) == 0);
      s_err = ($urandom_range(15) == 0);
      s_rty = ($urandom_range(15) == 0);
      s_dr  = $urandom;
      sample();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2.md
Name: wb_arbiter_2

Overview:
- Two-master to one-slave Wishbone arbiter for the core bus.
- m0 is the data/MEM port and m1 the instruction-fetch port; the single slave port feeds the 3-port address-decode multiplexer.
- Holds a grant for a master's whole cyc, arbitrates round-robin or fixed priority, and terminates hung transfers with a timeout err.

Parameters:
DATA_WIDTH, 32, data bus width in bits
ADDR_WIDTH, 32, address width in bits
SELECT_WIDTH, DATA_WIDTH/8, byte-select width
ROUND_ROBIN, 1, 1 = alternate on contention; 0 = m0 always wins
TIMEOUT, 255, response-wait limit in cycles; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
m0_adr_i, m1_adr_i  in  ADDR_WIDTH  master address
m0_dat_i, m1_dat_i  in  DATA_WIDTH  master write data
m0_dat_o, m1_dat_o  out  DATA_WIDTH  read data to master
m0_we_i, m1_we_i  in  1  write enable
m0_sel_i, m1_sel_i  in  SELECT_WIDTH  byte selects
m0_stb_i, m1_stb_i  in  1  strobe
m0_cyc_i, m1_cyc_i  in  1  cycle
m0_ack_o, m1_ack_o  out  1  acknowledge
m0_err_o, m1_err_o  out  1  error (slave err or timeout)
m0_rty_o, m1_rty_o  out  1  retry
s_adr_o  out  ADDR_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_dat_i  in  DATA_WIDTH  slave read data
s_we_o  out  1  slave write enable
s_sel_o  out  SELECT_WIDTH  slave byte selects
s_stb_o  out  1  slave strobe
s_cyc_o  out  1  slave cycle
s_ack_i, s_err_i, s_rty_i  in  1  slave responses
grant_o  out  2  one-hot current grant; 00 = idle

Behaviour:
- Request: reqN = mN_cyc_i & mN_stb_i.
- Reset (rst=0, asynchronous):
  - state=IDLE, last=1 (m0 wins first), wait_cnt=0, to_err=0.
  - All outputs 0 immediately, including mid-transfer.
- States: IDLE, G0, G1. The grant is registered.
- IDLE:
  - req0 only -> G0; req1 only -> G1.
  - Both requesting: ROUND_ROBIN=1 picks the master that is not `last`; ROUND_ROBIN=0 picks m0.
  - On entry to G0/G1, `last` is updated to that master.
- GN: stay while mN_cyc_i=1, so multiple stb beats and burst gaps stay granted. mN_cyc_i=0 -> IDLE.
- Arbitration latency: a request seen in an IDLE cycle appears on s_* in the next cycle. At least one IDLE cycle separates consecutive grants.
- Slave drive:
  - In GN, s_adr/dat/we/sel come from mN.
  - s_cyc_o = mN_cyc_i & ~to_err; s_stb_o = mN_stb_i & ~to_err.
  - In IDLE, all s_* = 0.
- Response routing (combinational, granted master only):
  - mN_ack_o = s_ack_i & grantN; mN_rty_o = s_rty_i & grantN.
  - mN_err_o = (s_err_i | to_err) & grantN.
  - mN_dat_o = s_dat_i if grantN, else 0.
  - The non-granted master sees all zeros.
- Timeout (TIMEOUT>0), counter width $clog2(TIMEOUT+1):
  - wait_cnt increments each cycle s_stb_o=1 with no ack/err/rty.
  - wait_cnt clears on any response, on s_stb_o=0, or in IDLE.
  - If wait_cnt==TIMEOUT-1 and there is still no response that cycle: to_err<=1 and wait_cnt<=0.
  - to_err lasts exactly one cycle: err to the granted master, s_cyc/s_stb forced 0.
  - Result: with stb first on the slave at cycle t and no response, err pulses at cycle t+TIMEOUT.
- Simultaneous events:
  - Slave ack in the same cycle the master drops cyc: the ack is still routed that cycle, then IDLE.
  - A response arriving on the timeout-deciding cycle wins and to_err is not set.
  - A timeout while cyc stays high keeps the grant; the next stb restarts the count.
- TIMEOUT=0: counter and to_err are held at 0.
- No combinational path from one master's inputs to the other master's outputs.

Test Plan:
- Single m1 read: req1 at cycle 0 -> grant_o=10 and s_stb_o=1 at cycle 1; s_ack_i=1 with s_dat_i=0xDEADBEEF at cycle 2 -> m1_ack_o=1, m1_dat_o=0xDEADBEEF, m0 outputs 0.
- Contention, ROUND_ROBIN=1: both request from reset -> m0 granted first. m0 drops cyc -> one IDLE cycle -> m1 granted. Repeat -> m0, m1 alternate. With ROUND_ROBIN=0, m0 is always granted.
- Held grant: m0 performs 3 stb beats with cyc high while m1 requests throughout -> grant_o stays 01 until m0 cyc drops.
- Timeout, TIMEOUT=4: m0 stb with no slave response -> m0_err_o=1 for one cycle exactly 4 cycles after s_stb_o first rose; s_stb_o=0 that cycle. Ack arriving at count 3 -> m0_ack_o=1 and no err.
- Reset mid-transfer: rst=0 while G1 with stb high -> s_cyc_o=0 and grant_o=00 without a clock edge. After release, a simultaneous request -> m0 granted.
